// File: rtl/hdlc_tx_channel_if.sv
// hdlc_tx_channel_if
// Groups the byte-feed handshake and serial-side status of one HDLC transmit
// channel. The client side uses the master modport; the channel uses slave.
//   Tx_Start        client -> channel  one-cycle frame start request
//   Tx_AbortFrame   client -> channel  abort request
//   Tx_Data[7:0]    client -> channel  next payload byte, sent LSB first
//   Tx_DataValid    client -> channel  Tx_Data holds a byte
//   Tx_Last         client -> channel  Tx_Data is the final byte of the frame
//   Tx              channel -> client  registered serial line
//   Tx_RdBuff       channel -> client  one-cycle byte-accept strobe
//   Tx_Done         channel -> client  one-cycle pulse on normal completion
//   Tx_AbortedTrans channel -> client  one-cycle pulse when an abort starts
//   Tx_Busy         channel -> client  high whenever not idle
//   Tx_ByteCount    channel -> client  bytes accepted this frame, saturating
interface hdlc_tx_channel_if;
  logic       Tx_Start;
  logic       Tx_AbortFrame;
  logic [7:0] Tx_Data;
  logic       Tx_DataValid;
  logic       Tx_Last;
  logic       Tx;
  logic       Tx_RdBuff;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;
  logic       Tx_Busy;
  logic [7:0] Tx_ByteCount;

  modport master (
    output Tx_Start, Tx_AbortFrame, Tx_Data, Tx_DataValid, Tx_Last,
    input  Tx, Tx_RdBuff, Tx_Done, Tx_AbortedTrans, Tx_Busy, Tx_ByteCount
  );

  modport slave (
    input  Tx_Start, Tx_AbortFrame, Tx_Data, Tx_DataValid, Tx_Last,
    output Tx, Tx_RdBuff, Tx_Done, Tx_AbortedTrans, Tx_Busy, Tx_ByteCount
  );
endinterface

// File: rtl/hdlc_tx_channel.sv
// hdlc_tx_channel
// HDLC transmit channel: opening flag, bit-stuffed payload (LSB first),
// closing flag; abort sequence on request or on buffer underrun.
//   Clk    rising-edge clock, one Tx bit per cycle
//   Rst    asynchronous active-low reset
//   tx_if  slave side of hdlc_tx_channel_if (handshake, serial line, status)
// r_tx always holds the bit currently on the line; each edge loads the next.
module hdlc_tx_channel #(
  parameter int STUFF_RUN = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  hdlc_tx_channel_if.slave tx_if
);

  localparam int               ONES_W    = $clog2(STUFF_RUN + 1);
  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_RUN);
  localparam logic [7:0]        FLAG      = 8'h7E;  // 0,1,1,1,1,1,1,0 LSB first

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START_FLAG = 3'd1,
    S_DATA       = 3'd2,
    S_END_FLAG   = 3'd3,
    S_ABORT      = 3'd4
  } state_t;

  state_t            r_state,      w_state_next;
  logic [2:0]        r_bit_idx,    w_bit_idx_next;
  logic [ONES_W-1:0] r_ones,       w_ones_next;
  logic [7:0]        r_byte,       w_byte_next;
  logic              r_last,       w_last_next;
  logic              r_tx,         w_tx_next;
  logic              r_rd_buff,    w_rd_buff_next;
  logic              r_done,       w_done_next;
  logic              r_aborted,    w_aborted_next;
  logic              r_busy,       w_busy_next;
  logic [7:0]        r_byte_count, w_byte_count_next;
  logic [2:0]        w_idx_inc;
  logic              w_go_abort;
  logic              w_byte_due;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? 8'd255 : v + 8'd1;
  endfunction

  // Run length of data 1s after driving bit b.
  function automatic logic [ONES_W-1:0] ones_after(input logic b, input logic [ONES_W-1:0] n);
    return b ? n + ONES_W'(1) : {ONES_W{1'b0}};
  endfunction

  assign w_idx_inc = r_bit_idx + 3'd1;

  // Next-state and next-output decode.
  always_comb begin
    w_state_next      = r_state;
    w_bit_idx_next    = r_bit_idx;
    w_ones_next       = r_ones;
    w_byte_next       = r_byte;
    w_last_next       = r_last;
    w_tx_next         = r_tx;
    w_rd_buff_next    = 1'b0;
    w_done_next       = 1'b0;
    w_aborted_next    = 1'b0;
    w_byte_count_next = r_byte_count;
    w_go_abort        = 1'b0;
    w_byte_due        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        // Abort beats start when both arrive together.
        if (tx_if.Tx_Start && !tx_if.Tx_AbortFrame) begin
          w_state_next      = S_START_FLAG;
          w_bit_idx_next    = 3'd0;
          w_tx_next         = FLAG[0];
          w_byte_count_next = 8'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START_FLAG: begin
        if (tx_if.Tx_AbortFrame) begin
          w_go_abort = 1'b1;
        end else if (r_bit_idx != 3'd7) begin
          w_bit_idx_next = w_idx_inc;
          w_tx_next      = FLAG[w_idx_inc];
        end else begin
          w_byte_due = 1'b1;
        end
      end
      S_DATA: begin
        if (tx_if.Tx_AbortFrame) begin
          w_go_abort = 1'b1;
        end else if (r_ones == STUFF_MAX) begin
          // Stuffed 0: bit index holds, so it may also trail bit 7.
          w_tx_next   = 1'b0;
          w_ones_next = {ONES_W{1'b0}};
        end else if (r_bit_idx != 3'd7) begin
          w_bit_idx_next = w_idx_inc;
          w_tx_next      = r_byte[w_idx_inc];
          w_ones_next    = ones_after(r_byte[w_idx_inc], r_ones);
        end else if (r_last) begin
          w_state_next   = S_END_FLAG;
          w_bit_idx_next = 3'd0;
          w_tx_next      = FLAG[0];
          w_ones_next    = {ONES_W{1'b0}};
        end else begin
          w_byte_due = 1'b1;
        end
      end
      S_END_FLAG: begin
        if (tx_if.Tx_AbortFrame) begin
          w_go_abort = 1'b1;
        end else if (r_bit_idx != 3'd7) begin
          w_bit_idx_next = w_idx_inc;
          w_tx_next      = FLAG[w_idx_inc];
        end else begin
          w_state_next   = S_IDLE;
          w_bit_idx_next = 3'd0;
          w_tx_next      = 1'b1;
          w_done_next    = 1'b1;
        end
      end
      S_ABORT: begin
        // Abort requests are ignored while the abort pattern plays out.
        if (r_bit_idx != 3'd7) begin
          w_bit_idx_next = w_idx_inc;
          w_tx_next      = 1'b1;
        end else begin
          w_state_next   = S_IDLE;
          w_bit_idx_next = 3'd0;
          w_tx_next      = 1'b1;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_bit_idx_next = 3'd0;
        w_tx_next      = 1'b1;
      end
    endcase

    // An accept falling due with no byte available is an underrun abort.
    if (w_go_abort || (w_byte_due && !tx_if.Tx_DataValid)) begin
      w_state_next   = S_ABORT;
      w_bit_idx_next = 3'd0;
      w_tx_next      = 1'b0;
      w_ones_next    = {ONES_W{1'b0}};
      w_aborted_next = 1'b1;
    end else if (w_byte_due) begin
      w_state_next      = S_DATA;
      w_bit_idx_next    = 3'd0;
      w_byte_next       = tx_if.Tx_Data;
      w_last_next       = tx_if.Tx_Last;
      w_tx_next         = tx_if.Tx_Data[0];
      w_ones_next       = ones_after(tx_if.Tx_Data[0], r_state == S_DATA ? r_ones : {ONES_W{1'b0}});
      w_rd_buff_next    = 1'b1;
      w_byte_count_next = sat_inc8(r_byte_count);
    end else begin
      w_rd_buff_next = 1'b0;
    end

    w_busy_next = (w_state_next != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state      <= S_IDLE;
      r_bit_idx    <= 3'd0;
      r_ones       <= {ONES_W{1'b0}};
      r_byte       <= 8'd0;
      r_last       <= 1'b0;
      r_tx         <= 1'b1;
      r_rd_buff    <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_busy       <= 1'b0;
      r_byte_count <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_bit_idx    <= w_bit_idx_next;
      r_ones       <= w_ones_next;
      r_byte       <= w_byte_next;
      r_last       <= w_last_next;
      r_tx         <= w_tx_next;
      r_rd_buff    <= w_rd_buff_next;
      r_done       <= w_done_next;
      r_aborted    <= w_aborted_next;
      r_busy       <= w_busy_next;
      r_byte_count <= w_byte_count_next;
    end
  end

  assign tx_if.Tx              = r_tx;
  assign tx_if.Tx_RdBuff       = r_rd_buff;
  assign tx_if.Tx_Done         = r_done;
  assign tx_if.Tx_AbortedTrans = r_aborted;
  assign tx_if.Tx_Busy         = r_busy;
  assign tx_if.Tx_ByteCount    = r_byte_count;

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// tb_hdlc_tx_channel
// Directed bench for hdlc_tx_channel. Each tick samples the outputs 1 time
// unit after the rising edge, shifts Tx into a capture vector (newest bit at
// LSB, so literals read left-to-right in time order) and counts pulses.
module tb_hdlc_tx_channel;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hdlc_tx_channel_if bus ();

  hdlc_tx_channel #(.STUFF_RUN(5)) dut (
    .Clk   (clk),
    .Rst   (rst_n),
    .tx_if (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] cap;
  int          n_rd, n_done, n_abt;
  logic [7:0]  q_data[$];
  bit          q_last[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present the head of the byte queue to the channel.
  task automatic feed();
    if (q_data.size() > 0) begin
      bus.Tx_Data      = q_data[0];
      bus.Tx_Last      = q_last[0];
      bus.Tx_DataValid = 1'b1;
    end else begin
      bus.Tx_Data      = 8'h00;
      bus.Tx_Last      = 1'b0;
      bus.Tx_DataValid = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] d, input bit l);
    q_data.push_back(d);
    q_last.push_back(l);
    feed();
  endtask

  task automatic flush();
    q_data.delete();
    q_last.delete();
    feed();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cap = {cap[62:0], bus.Tx};
    if (bus.Tx_Done)         n_done++;
    if (bus.Tx_AbortedTrans) n_abt++;
    if (bus.Tx_RdBuff) begin
      n_rd++;
      void'(q_data.pop_front());
      void'(q_last.pop_front());
      feed();
    end
  endtask

  task automatic new_frame();
    cap = 64'd0; n_rd = 0; n_done = 0; n_abt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Tx_Start = 1'b0;
    bus.Tx_AbortFrame = 1'b0;
    feed();
    new_frame();

    // Reset state
    #12;
    check("rst_tx", bus.Tx, 1);
    check("rst_busy", bus.Tx_Busy, 0);
    check("rst_count", bus.Tx_ByteCount, 0);
    check("rst_pulses", {bus.Tx_RdBuff, bus.Tx_Done, bus.Tx_AbortedTrans}, 0);
    #10 rst_n = 1'b1;

    // Start and abort together in IDLE: abort wins, nothing happens
    bus.Tx_Start = 1'b1; bus.Tx_AbortFrame = 1'b1;
    tick();
    bus.Tx_Start = 1'b0; bus.Tx_AbortFrame = 1'b0;
    check("start_abort_busy", bus.Tx_Busy, 0);
    check("start_abort_tx", bus.Tx, 1);
    check("start_abort_pulse", n_abt, 0);

    // Frame 0x00 last
    new_frame();
    push(8'h00, 1'b1);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    repeat (23) tick();
    check("f00_bits", cap[23:0], 24'b01111110_00000000_01111110);
    tick();
    check("f00_done", bus.Tx_Done, 1);
    check("f00_idle_tx", bus.Tx, 1);
    check("f00_busy", bus.Tx_Busy, 0);
    check("f00_rd", n_rd, 1);
    check("f00_count", bus.Tx_ByteCount, 1);

    // Frame 0xFF started in the first IDLE cycle (back-to-back)
    new_frame();
    push(8'hFF, 1'b1);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    check("fff_b2b_busy", bus.Tx_Busy, 1);
    repeat (24) tick();
    check("fff_bits", cap[24:0], 25'b01111110_111110111_01111110);
    tick();
    check("fff_done", n_done, 1);
    tick();
    check("fff_done_1cyc", bus.Tx_Done, 0);
    check("fff_count", bus.Tx_ByteCount, 1);

    // Frame 0xF0, 0x0F: stuffed 0 across the byte boundary
    new_frame();
    push(8'hF0, 1'b0);
    push(8'h0F, 1'b1);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    repeat (32) tick();
    check("f2b_bits", cap[32:0], 33'b01111110_00001111_10_1110000_01111110);
    tick();
    check("f2b_done", n_done, 1);
    check("f2b_rd", n_rd, 2);
    check("f2b_count", bus.Tx_ByteCount, 2);

    // Abort request while the 3rd data bit is on the line
    new_frame();
    push(8'hA5, 1'b0);
    push(8'h5A, 1'b1);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    repeat (10) tick();
    bus.Tx_AbortFrame = 1'b1;
    tick();
    bus.Tx_AbortFrame = 1'b0;
    check("abt_pulse_now", bus.Tx_AbortedTrans, 1);
    repeat (9) tick();
    check("abt_bits", cap[20:0], 21'b01111110_101_01111111_11);
    check("abt_pulses", n_abt, 1);
    check("abt_no_done", n_done, 0);
    check("abt_busy", bus.Tx_Busy, 0);
    flush();

    // Underrun at the second accept
    new_frame();
    push(8'h55, 1'b0);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    repeat (24) tick();
    check("urun_bits", cap[24:0], 25'b01111110_10101010_01111111_1);
    check("urun_abt", n_abt, 1);
    check("urun_done", n_done, 0);
    check("urun_count", bus.Tx_ByteCount, 1);
    check("urun_busy", bus.Tx_Busy, 0);

    // Reset in the middle of DATA, then a clean frame
    new_frame();
    push(8'h3C, 1'b1);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    repeat (11) tick();
    check("mid_busy_before", bus.Tx_Busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", bus.Tx, 1);
    check("mid_rst_busy", bus.Tx_Busy, 0);
    check("mid_rst_count", bus.Tx_ByteCount, 0);
    check("mid_rst_pulses", {bus.Tx_RdBuff, bus.Tx_Done, bus.Tx_AbortedTrans}, 0);
    #10 rst_n = 1'b1;
    flush();
    new_frame();
    repeat (2) tick();
    check("post_rst_silent", {n_done[7:0], n_abt[7:0]}, 0);
    check("post_rst_tx", bus.Tx, 1);
    push(8'h00, 1'b1);
    bus.Tx_Start = 1'b1;
    tick();
    bus.Tx_Start = 1'b0;
    repeat (23) tick();
    check("post_rst_bits", cap[23:0], 24'b01111110_00000000_01111110);
    tick();
    check("post_rst_done", n_done, 1);
    check("post_rst_count", bus.Tx_ByteCount, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_channel.md
HDLC_TX_CHANNEL -- requirements
Module: hdlc_tx_channel

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clk and Rst.
REQ-002 Parameter STUFF_RUN, default 5: the number of consecutive data 1s that triggers zero insertion. It SHALL be 5 for HDLC use.
REQ-003 Clk  in  1  rising-edge clock; one bit is driven on Tx per cycle.
REQ-004 Rst  in  1  asynchronous, active-low reset.
REQ-005 Tx_Start  in  1  one-cycle frame start request; sampled only in IDLE.
REQ-006 Tx_AbortFrame  in  1  abort request.
REQ-007 Tx_Data  in  8  next payload byte, sent LSB first.
REQ-008 Tx_DataValid  in  1  Tx_Data holds a byte.
REQ-009 Tx_Last  in  1  qualifies Tx_Data as the final byte of the frame.
REQ-010 Tx  out  1  serial line, registered.
REQ-011 Tx_RdBuff  out  1  one-cycle byte-accept strobe.
REQ-012 Tx_Done  out  1  one-cycle pulse on normal frame completion.
REQ-013 Tx_AbortedTrans  out  1  one-cycle pulse when an abort starts.
REQ-014 Tx_Busy  out  1  high in any state other than IDLE.
REQ-015 Tx_ByteCount  out  8  bytes accepted in the current frame; saturates at 255.

Function
REQ-016 The state machine SHALL have the states IDLE, START_FLAG, DATA, END_FLAG and ABORT.
REQ-017 In IDLE, Tx SHALL be 1 (idle pattern: continuous 1s).
REQ-018 IDLE -> START_FLAG SHALL occur when Tx_Start=1 and Tx_AbortFrame=0 at a clock edge. Tx_ByteCount SHALL clear on this edge.
REQ-019 After the edge of REQ-018, flag bit 0 SHALL appear on Tx in the next cycle.
REQ-020 START_FLAG and END_FLAG SHALL each drive the flag 0,1,1,1,1,1,1,0 over 8 cycles, with no zero insertion.
REQ-021 Byte accept: Tx_RdBuff=1 for one cycle; Tx_Data and Tx_Last SHALL be captured at that edge, and bit 0 of the byte SHALL be driven from that edge onward.
REQ-022 The first accept SHALL take place on the edge after which flag bit 7 has been driven.
REQ-023 Each subsequent accept SHALL take place on the edge after which the previous byte's bit 7, or its trailing stuffed 0, has been driven. There SHALL be no idle gap between bytes.
REQ-024 Tx_ByteCount SHALL increment on each accept.
REQ-025 Zero insertion: a ones counter SHALL count consecutive data 1s driven. When it reaches STUFF_RUN, the next Tx bit SHALL be a 0 and the counter SHALL clear.
REQ-026 The ones counter SHALL also clear on any data 0, SHALL carry across byte boundaries, and SHALL clear on entry to DATA.
REQ-027 A stuffed 0 SHALL not advance the bit index.
REQ-028 After the last bit of a byte captured with Tx_Last=1 (including any stuffed 0), the block SHALL enter END_FLAG with no accept.
REQ-029 Underrun: if Tx_DataValid=0 when an accept is due and the last byte has not been sent, the block SHALL enter ABORT.
REQ-030 Abort: Tx_AbortFrame=1 sampled in START_FLAG, DATA or END_FLAG SHALL enter ABORT at that edge, and Tx_AbortedTrans SHALL pulse on the same edge.
REQ-031 In ABORT, Tx SHALL drive 0 followed by seven 1s (8 cycles), then the block SHALL return to IDLE without pulsing Tx_Done.
REQ-032 Tx_AbortFrame in IDLE or ABORT SHALL be ignored. Tx_Start outside IDLE SHALL be ignored.
REQ-033 Tx_Start and Tx_AbortFrame high together in IDLE: abort SHALL take priority, so no frame starts and no pulse is generated.
REQ-034 Tx_Done SHALL pulse for one cycle on the edge at which END_FLAG bit 7 completes, and the state SHALL return to IDLE on that edge.
REQ-035 Back-to-back frames: Tx_Start SHALL be accepted in the first IDLE cycle.

Reset
REQ-036 While Rst=0, immediately and regardless of Clk: state=IDLE, Tx=1, and Tx_RdBuff, Tx_Done, Tx_AbortedTrans, Tx_Busy, Tx_ByteCount and the ones counter SHALL all be 0.
REQ-037 Reset mid-frame SHALL discard the frame silently, with no Tx_Done and no Tx_AbortedTrans. The first post-reset edge SHALL see IDLE.

Verification
REQ-038 Frame 0x00, Tx_Last=1 -> Tx 01111110 00000000 01111110; one Tx_RdBuff pulse; Tx_Done pulse; Tx_ByteCount=1.
REQ-039 Frame 0xFF, Tx_Last=1 -> data field 111110111 (9 cycles); frame is 25 cycles flag-to-flag.
REQ-040 Frame 0xF0, 0x0F -> data field 00001111 1 0 1110000, with a stuffed 0 across the byte boundary; two Tx_RdBuff pulses.
REQ-041 Tx_AbortFrame at the 3rd data bit -> Tx 0,1,1,1,1,1,1,1, then 1s; one Tx_AbortedTrans pulse; no end flag; no Tx_Done.
REQ-042 Tx_DataValid=0 at the second accept with Tx_Last=0 -> abort pattern and a Tx_AbortedTrans pulse; Tx_ByteCount=1.
REQ-043 Rst low mid-DATA -> Tx=1 and all other outputs 0 asynchronously; a new Tx_Start after release produces a correct frame.
